int_ctrl: RTL
=============

Name: int_ctrl

Overview:
- Prioritised interrupt controller directly downstream of the timer and other peripheral interrupt sources.
- Captures the one-cycle `interrupt` pulses (and any other rising-edge requests) into a pending register and applies a mask.
- Presents one request with a vector to the CPU, then runs a request/acknowledge/end-of-interrupt handshake.
- The CPU accesses it through the same 8-bit byte-wide register style the peripherals use.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8); src[0] is highest priority.
- VEC_BASE, 8'h10, vector emitted for source 0.
- VEC_STRIDE, 4, vector spacing; vector = VEC_BASE + idx*VEC_STRIDE, modulo 256.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- irq  in  NUM_SRC  source lines; rising edge = event. Timer `interrupt` wires to irq[0].
- addr  in  2  register select.
- wdata  in  8  write data.
- we  in  1  register write strobe, one cycle.
- rdata  out  8  read data, combinational from addr.
- int_req  out  1  request to CPU, registered.
- vector  out  8  vector of the latched source, registered.
- int_ack  in  1  CPU accept strobe, one cycle.

Behaviour:
- Reset (synchronous, active-high):
  - mask, pending, GIE, in-service index, vector and int_req all 0; state IDLE.
  - irq_q loads irq during reset, so a line already high at reset release is not an event.
- Edge detect: `edge = irq & ~irq_q`, with `irq_q <= irq` every cycle.
  - An edge sampled at posedge E sets its pending bit at E.
  - A line held high counts as one event.
  - A second edge while that bit is already pending is lost (no counting).
- Register map (unused bits read 0):
  - addr 0 MASK: R/W, bit i enables source i.
  - addr 1 PENDING: read; write-1-to-clear.
  - addr 2 STATUS: read-only. bit7 = in_service; bit6 = requesting; bits[2:0] = latched source index.
  - addr 3 CONTROL: bit0 = GIE (R/W). Writing bit1=1 is EOI; it is self-clearing and reads 0.
- Pending-bit conflicts: a set from edge wins over a W1C write or an ack-clear on the same bit in the same cycle.
- State machine:
  - IDLE:
    - If GIE=1 and (pending & mask) != 0 at posedge: select the lowest set index, latch idx and vector, set int_req, go to REQUEST.
    - Latency: irq first sampled high at E → int_req high after E+1.
  - REQUEST:
    - int_req=1; vector and idx are frozen. A higher-priority arrival does not re-arbitrate.
    - int_ack=1: clear pending[idx], int_req←0, go to SERVICE.
    - GIE written 0 (without ack): int_req←0, back to IDLE, pending untouched.
    - Ack has priority over a same-cycle GIE clear.
    - Masking the latched source in REQUEST does not retract the request.
  - SERVICE:
    - int_req=0; no new request regardless of pending.
    - EOI write → IDLE at that posedge. Re-arbitration can raise int_req at the following posedge.
- Ignored inputs:
  - int_ack outside REQUEST.
  - EOI outside SERVICE.
- Index and arithmetic: idx is 3 bits; vector arithmetic is 8-bit wrap; pending/mask bits above NUM_SRC-1 are always 0.
- Reset mid-operation: returns to IDLE in one cycle, int_req low after that edge, all pending events discarded.

Test Plan:
- Reset, MASK=8'h01, GIE=1, pulse irq[0] one cycle at edge E → PENDING reads 8'h01 after E; int_req=1 and vector=8'h10 after E+1; STATUS=8'h40.
- Pulse irq[2] and irq[5] in the same cycle with MASK=8'hFF → vector=8'h18. Then:
  - ack → STATUS=8'h82, PENDING=8'h20.
  - EOI → vector=8'h24 two cycles later.
  - ack, EOI → PENDING=8'h00, int_req stays 0.
- Hold irq[1] high 10 cycles, MASK=0 → PENDING=8'h02 (one event), int_req=0. Write PENDING 8'h02 → 8'h00. Set MASK=8'h02 → no request.
- In REQUEST for irq[3], pulse irq[0] → vector stays 8'h1C until ack. After EOI the next request is vector 8'h10.
- W1C of bit 4 coincident with a new irq[4] edge → PENDING bit4 remains 1.
- Assert reset while in SERVICE with PENDING=8'h06 → after one edge: int_req=0, PENDING=0, STATUS=0, CONTROL=0. irq held high through reset does not set pending.

Source files
------------

// File: rtl/int_ctrl.sv
`timescale 1ns/1ps
// int_ctrl: prioritised interrupt controller.
// Rising edges on irq are captured into a pending register and gated by a mask.
// The lowest-numbered active source is presented to the CPU with a vector.
// The CPU then runs the request / acknowledge / end-of-interrupt handshake.
// The CPU sees four byte-wide registers: MASK, PENDING, STATUS and CONTROL.
module int_ctrl #(
  parameter int         NUM_SRC    = 8,
  parameter logic [7:0] VEC_BASE   = 8'h10,
  parameter int         VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [1:0]         addr,
  input  logic [7:0]         wdata,
  input  logic               we,
  output logic [7:0]         rdata,
  output logic               int_req,
  output logic [7:0]         vector,
  input  logic               int_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [NUM_SRC-1:0] irq_q_reg;
  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic               gie_reg;
  logic [2:0]         idx_reg;
  logic [7:0]         vector_reg;
  logic               int_req_reg;

  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] w1c_clr;
  logic [NUM_SRC-1:0] pending_next;
  logic [2:0]         sel_idx;
  logic [7:0]         vec_calc;
  logic [7:0]         mask_rd;
  logic [7:0]         pending_rd;

  logic wr_mask;
  logic wr_pend;
  logic wr_ctrl;
  logic ack_fire;
  logic eoi;
  logic gie_off;

  assign wr_mask  = we && (addr == 2'd0);
  assign wr_pend  = we && (addr == 2'd1);
  assign wr_ctrl  = we && (addr == 2'd3);

  // Ack is only meaningful while a request is outstanding.
  // EOI is only meaningful while a source is in service.
  assign ack_fire = (state_reg == REQUEST) && int_ack;
  assign eoi      = wr_ctrl && wdata[1] && (state_reg == SERVICE);
  assign gie_off  = wr_ctrl && !wdata[0];

  assign edge_det = irq & ~irq_q_reg;
  assign active   = pending_reg & mask_reg;
  assign w1c_clr  = wr_pend ? wdata[NUM_SRC-1:0] : '0;

  // Clears are applied first and the edge set is ORed in last.
  // As a result, a fresh edge survives a same-cycle W1C or ack-clear.
  assign pending_next = (pending_reg & ~(w1c_clr | ack_clr)) | edge_det;

  genvar gi;
  generate
    // One-hot clear of the acknowledged source.
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ack
      assign ack_clr[gi] = ack_fire && (idx_reg == 3'(gi));
    end
    // Byte-wide register views; bits beyond the implemented sources read 0.
    for (gi = 0; gi < 8; gi++) begin : g_rd
      if (gi < NUM_SRC) begin : g_on
        assign mask_rd[gi]    = mask_reg[gi];
        assign pending_rd[gi] = pending_reg[gi];
      end else begin : g_off
        assign mask_rd[gi]    = 1'b0;
        assign pending_rd[gi] = 1'b0;
      end
    end
  endgenerate

  // Fixed-priority select: the lowest-numbered active source wins.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_idx = 3'(i);
      end
    end
  end

  // The vector wraps modulo 256 through the 8-bit truncation.
  assign vec_calc = VEC_BASE + 8'(int'(sel_idx) * VEC_STRIDE);

  // Register read mux, combinational from addr.
  always_comb begin
    rdata = 8'h00;
    case (addr)
      2'd0: rdata = mask_rd;
      2'd1: rdata = pending_rd;
      2'd2: rdata = {(state_reg == SERVICE), (state_reg == REQUEST), 3'b000, idx_reg};
      2'd3: rdata = {7'd0, gie_reg};
      default: rdata = 8'h00;
    endcase
  end

  // Edge history, mask, pending and global-enable registers.
  // While in reset, irq_q tracks irq, so a line held high across reset release is not an event.
  always_ff @(posedge clk) begin
    irq_q_reg <= irq;
    if (reset) begin
      mask_reg    <= '0;
      pending_reg <= '0;
      gie_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (wr_mask) begin
        mask_reg <= wdata[NUM_SRC-1:0];
      end
      if (wr_ctrl) begin
        gie_reg <= wdata[0];
      end
    end
  end

  // Handshake FSM with registered int_req, vector and latched index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      int_req_reg <= 1'b0;
      vector_reg  <= 8'h00;
      idx_reg     <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gie_reg && (|active)) begin
            idx_reg     <= sel_idx;
            vector_reg  <= vec_calc;
            int_req_reg <= 1'b1;
            state_reg   <= REQUEST;
          end
        end
        REQUEST: begin
          // Ack wins over a same-cycle GIE clear.
          // Neither masking nor a higher-priority arrival re-arbitrates.
          if (int_ack) begin
            int_req_reg <= 1'b0;
            state_reg   <= SERVICE;
          end else if (gie_off) begin
            int_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          int_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign int_req = int_req_reg;
  assign vector  = vector_reg;

endmodule
